// File: rtl/fifo_reader.sv
// Pop-side adapter: drains a Fifo into a registered val/rdy stream through a 2-entry skid buffer.
// Optional transfer counter enabled by defining FIFO_READER_STATS_EN.
module fifo_reader #(
    parameter type t_entry      = logic [31:0],
    parameter int  p_count_bits = 16
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   fifo_empty,
    output logic   fifo_pop,
    input  t_entry fifo_rdata,
    output logic   ostream_val,
    input  logic   ostream_rdy,
    output t_entry ostream_msg
`ifdef FIFO_READER_STATS_EN
    ,
    output logic [p_count_bits-1:0] xfer_count
`endif
);

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2
    } state_e;

    state_e r_state;
    state_e w_nextState;
    t_entry r_buf0;
    t_entry r_buf1;
    t_entry w_buf0Next;
    t_entry w_buf1Next;
    logic   w_pop;
    logic   w_xfer;

    // Pop never looks at ostream_rdy; the second slot absorbs a stalled cycle.
    assign w_pop       = !rst && !fifo_empty && (r_state != S2);
    assign w_xfer      = (r_state != S0) && ostream_rdy;
    assign fifo_pop    = w_pop;
    assign ostream_val = (r_state != S0);
    assign ostream_msg = r_buf0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S0;
        end else begin
            r_state <= w_nextState;
        end
        r_buf0 <= w_buf0Next;
        r_buf1 <= w_buf1Next;
    end

    always_comb begin
        w_nextState = r_state;
        w_buf0Next  = r_buf0;
        w_buf1Next  = r_buf1;
        case (r_state)
            S0: begin
                if (w_pop) begin
                    w_nextState = S1;
                    w_buf0Next  = fifo_rdata;
                end
            end
            S1: begin
                if (w_pop && !w_xfer) begin
                    w_nextState = S2;
                    w_buf1Next  = fifo_rdata;
                end else if (w_pop && w_xfer) begin
                    w_buf0Next  = fifo_rdata;
                end else if (w_xfer) begin
                    w_nextState = S0;
                end
            end
            S2: begin
                if (w_xfer) begin
                    w_nextState = S1;
                    w_buf0Next  = r_buf1;
                end
            end
            default: begin
                w_nextState = S0;
            end
        endcase
    end

`ifdef FIFO_READER_STATS_EN
    logic [p_count_bits-1:0] r_xferCount;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_xferCount <= '0;
        end else if (w_xfer) begin
            r_xferCount <= r_xferCount + 1'b1;
        end
    end

    assign xfer_count = r_xferCount;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Directed self-checking bench for fifo_reader with a small Fifo model driving the pop side.
// Counter checks run only when FIFO_READER_STATS_EN is defined.
module tb_fifo_reader;

    logic        clk;
    logic        rst;
    logic        fifo_empty;
    logic        fifo_pop;
    logic [31:0] fifo_rdata;
    logic        ostream_val;
    logic        ostream_rdy;
    logic [31:0] ostream_msg;
`ifdef FIFO_READER_STATS_EN
    logic [1:0]  xfer_count;
`endif

    int testsRun;
    int testsFailed;
    logic [31:0] fifoQ[$];

    fifo_reader #(
        .t_entry      (logic [31:0]),
        .p_count_bits (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fifo_empty  (fifo_empty),
        .fifo_pop    (fifo_pop),
        .fifo_rdata  (fifo_rdata),
        .ostream_val (ostream_val),
        .ostream_rdy (ostream_rdy),
        .ostream_msg (ostream_msg)
`ifdef FIFO_READER_STATS_EN
        ,
        .xfer_count  (xfer_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic driveHead();
        fifo_empty = (fifoQ.size() == 0);
        fifo_rdata = (fifoQ.size() != 0) ? fifoQ[0] : 32'h0;
    endtask

    // Called at a negedge; the Fifo model drops its head if a pop was seen for this edge.
    task automatic advance();
        logic popSeen;
        popSeen = fifo_pop;
        @(posedge clk);
        #1;
        if (popSeen && fifoQ.size() != 0) void'(fifoQ.pop_front());
        driveHead();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ostream_rdy = 1'b0;
        fifoQ.delete();
        driveHead();
        @(negedge clk);
        testsRun++;
        if (fifo_pop !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_pop: got %b, expected 0", fifo_pop);
        end
        advance();
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            testsRun++;
            if (fifo_pop !== 1'b0 || ostream_val !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL reset_idle cycle %0d: got pop=%b val=%b, expected pop=0 val=0",
                         c, fifo_pop, ostream_val);
            end
            advance();
        end
    endtask

    task automatic test_single();
        fifoQ.push_back(32'hdeadbeef);
        driveHead();
        ostream_rdy = 1'b1;
        @(negedge clk);
        testsRun++;
        if (fifo_pop !== 1'b1 || ostream_val !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL single_pop: got pop=%b val=%b, expected pop=1 val=0", fifo_pop, ostream_val);
        end
        advance();
        @(negedge clk);
        testsRun++;
        if (fifo_pop !== 1'b0 || ostream_val !== 1'b1 || ostream_msg !== 32'hdeadbeef) begin
            testsFailed++;
            $display("[TB] FAIL single_out: got pop=%b val=%b msg=%h, expected pop=0 val=1 msg=deadbeef",
                     fifo_pop, ostream_val, ostream_msg);
        end
        advance();
        @(negedge clk);
        testsRun++;
        if (ostream_val !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL single_drain: got val=%b, expected 0", ostream_val);
        end
        advance();
    endtask

    task automatic test_stream();
        logic expPop;
        logic expVal;
        for (int i = 1; i <= 4; i++) fifoQ.push_back(32'(i));
        driveHead();
        ostream_rdy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            expPop = (k < 4);
            expVal = (k >= 1 && k <= 4);
            @(negedge clk);
            testsRun++;
            if (fifo_pop !== expPop || ostream_val !== expVal ||
                (expVal && ostream_msg !== 32'(k))) begin
                testsFailed++;
                $display("[TB] FAIL stream cycle %0d: got pop=%b val=%b msg=%h, expected pop=%b val=%b msg=%h",
                         k, fifo_pop, ostream_val, ostream_msg, expPop, expVal, 32'(k));
            end
            advance();
        end
    endtask

    task automatic test_back_to_back();
        logic expPop[9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic expVal[9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] expMsg[9] = '{32'h0, 32'h1, 32'h1, 32'h1, 32'h1, 32'h2, 32'h3, 32'h4, 32'h0};
        for (int i = 1; i <= 4; i++) fifoQ.push_back(32'(i));
        driveHead();
        ostream_rdy = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (k == 4) ostream_rdy = 1'b1;
            @(negedge clk);
            testsRun++;
            if (fifo_pop !== expPop[k] || ostream_val !== expVal[k] ||
                (expVal[k] && ostream_msg !== expMsg[k])) begin
                testsFailed++;
                $display("[TB] FAIL stall cycle %0d: got pop=%b val=%b msg=%h, expected pop=%b val=%b msg=%h",
                         k, fifo_pop, ostream_val, ostream_msg, expPop[k], expVal[k], expMsg[k]);
            end
            advance();
        end
    endtask

    task automatic test_mid_reset();
        fifoQ.push_back(32'h1);
        fifoQ.push_back(32'h2);
        driveHead();
        ostream_rdy = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            advance();
        end
        @(negedge clk);
        testsRun++;
        if (fifo_pop !== 1'b0 || ostream_val !== 1'b1 || ostream_msg !== 32'h1) begin
            testsFailed++;
            $display("[TB] FAIL full_hold: got pop=%b val=%b msg=%h, expected pop=0 val=1 msg=00000001",
                     fifo_pop, ostream_val, ostream_msg);
        end
        advance();
        rst = 1'b1;
        fifoQ.delete();
        driveHead();
        @(negedge clk);
        advance();
        rst = 1'b0;
        @(negedge clk);
        testsRun++;
        if (fifo_pop !== 1'b0 || ostream_val !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL midreset_clear: got pop=%b val=%b, expected pop=0 val=0", fifo_pop, ostream_val);
        end
        advance();
        fifoQ.push_back(32'h5);
        driveHead();
        ostream_rdy = 1'b1;
        @(negedge clk);
        advance();
        @(negedge clk);
        testsRun++;
        if (ostream_val !== 1'b1 || ostream_msg !== 32'h5) begin
            testsFailed++;
            $display("[TB] FAIL midreset_fresh: got val=%b msg=%h, expected val=1 msg=00000005",
                     ostream_val, ostream_msg);
        end
        advance();
        @(negedge clk);
        testsRun++;
        if (ostream_val !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL midreset_alone: got val=%b, expected 0", ostream_val);
        end
        advance();
    endtask

`ifdef FIFO_READER_STATS_EN
    task automatic test_stats();
        logic [1:0] expCount[7] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        rst = 1'b1;
        fifoQ.delete();
        driveHead();
        @(negedge clk);
        advance();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) fifoQ.push_back(32'h10 + 32'(i));
        driveHead();
        ostream_rdy = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            testsRun++;
            if (xfer_count !== expCount[k]) begin
                testsFailed++;
                $display("[TB] FAIL xfer_count cycle %0d: got %0d, expected %0d", k, xfer_count, expCount[k]);
            end
            advance();
        end
        rst = 1'b1;
        @(negedge clk);
        advance();
        rst = 1'b0;
        @(negedge clk);
        testsRun++;
        if (xfer_count !== 2'd0) begin
            testsFailed++;
            $display("[TB] FAIL xfer_count_reset: got %0d, expected 0", xfer_count);
        end
        advance();
    endtask
`endif

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        test_reset();
        test_single();
        test_stream();
        test_back_to_back();
        test_mid_reset();
`ifdef FIFO_READER_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
